// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU command sequencer:
//   - command opcodes (4-bit, all 16 values legal)
//   - ALU operation encodings driven on alu_op
//   - carry-in source selection used by the decoder
//   - 2-bit FSM state encoding
//   - decoded control bundle passed from alu_seq_dec to alu_seq
// -----------------------------------------------------------------------------
package alu_seq_pkg;

  localparam logic [3:0] OP_ROL   = 4'd0;
  localparam logic [3:0] OP_SLL   = 4'd1;
  localparam logic [3:0] OP_ROR   = 4'd2;
  localparam logic [3:0] OP_SRL   = 4'd3;
  localparam logic [3:0] OP_ADD   = 4'd4;
  localparam logic [3:0] OP_SUB   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_AND   = 4'd8;
  localparam logic [3:0] OP_ANDN  = 4'd9;
  localparam logic [3:0] OP_SEQ   = 4'd10;
  localparam logic [3:0] OP_SLT   = 4'd11;
  localparam logic [3:0] OP_SLE   = 4'd12;
  localparam logic [3:0] OP_SCO   = 4'd13;
  localparam logic [3:0] OP_ADD32 = 4'd14;
  localparam logic [3:0] OP_SUB32 = 4'd15;

  typedef enum logic [2:0] {
    ALU_ROL = 3'd0,
    ALU_SLL = 3'd1,
    ALU_ROR = 3'd2,
    ALU_SRL = 3'd3,
    ALU_ADD = 3'd4,
    ALU_OR  = 3'd5,
    ALU_XOR = 3'd6,
    ALU_AND = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    CIN_ZERO  = 2'd0,
    CIN_ONE   = 2'd1,
    CIN_CARRY = 2'd2
  } cin_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC1 = 2'd1,
    ST_EXEC2 = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef struct packed {
    alu_op_e  alu_op;
    cin_sel_e cin_sel;
    logic     inva;
    logic     invb;
    logic     sign;
    logic     two_pass;
  } dec_t;

  // Ops whose response carries the ALU signed-overflow flag.
  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADD32) || (op == OP_SUB32);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// -----------------------------------------------------------------------------
// alu_seq_if
// Command / response handshake bundle between decode (master) and the ALU
// sequencer (slave).
//   cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b : command channel
//   rsp_valid/rsp_ready/rsp_data/rsp_ofl/rsp_zero : response channel
// -----------------------------------------------------------------------------
interface alu_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_ofl;
  logic        rsp_zero;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ofl, rsp_zero
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_ofl, rsp_zero
  );
endinterface

// File: rtl/alu_seq_dec.sv
// -----------------------------------------------------------------------------
// alu_seq_dec
// Combinational opcode decoder: maps a command opcode and the current pass
// (0 = first/only pass, 1 = high-half pass of ADD32/SUB32) onto ALU controls.
//   op   in  4   command opcode
//   pass in  1   0 = pass 1, 1 = pass 2
//   ctl  out     {alu_op, cin_sel, inva, invb, sign, two_pass}
// -----------------------------------------------------------------------------
module alu_seq_dec
  import alu_seq_pkg::*;
(
  input  logic [3:0] op,
  input  logic       pass,
  output dec_t       ctl
);

  // NOTE: every field gets a default before the case so no path leaves ctl
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    ctl = '0;
    unique case (op)
      OP_ROL:  ctl.alu_op = ALU_ROL;
      OP_SLL:  ctl.alu_op = ALU_SLL;
      OP_ROR:  ctl.alu_op = ALU_ROR;
      OP_SRL:  ctl.alu_op = ALU_SRL;
      OP_ADD: begin
        ctl.alu_op = ALU_ADD;
        ctl.sign   = 1'b1;
      end
      // Subtract and all compares are A + ~B + 1 with signed overflow.
      OP_SUB, OP_SEQ, OP_SLT, OP_SLE: begin
        ctl.alu_op  = ALU_ADD;
        ctl.invb    = 1'b1;
        ctl.cin_sel = CIN_ONE;
        ctl.sign    = 1'b1;
      end
      OP_OR:   ctl.alu_op = ALU_OR;
      OP_XOR:  ctl.alu_op = ALU_XOR;
      OP_AND:  ctl.alu_op = ALU_AND;
      OP_ANDN: begin
        ctl.alu_op = ALU_AND;
        ctl.invb   = 1'b1;
      end
      // Unsigned add: alu_ofl reports the carry-out.
      OP_SCO:  ctl.alu_op = ALU_ADD;
      OP_ADD32, OP_SUB32: begin
        ctl.alu_op   = ALU_ADD;
        ctl.two_pass = 1'b1;
        ctl.invb     = (op == OP_SUB32);
        if (pass) begin
          ctl.cin_sel = CIN_CARRY;
          ctl.sign    = 1'b1;
        end else begin
          // Low half reports carry-out so it can be chained into pass 2.
          ctl.cin_sel = (op == OP_SUB32) ? CIN_ONE : CIN_ZERO;
          ctl.sign    = 1'b0;
        end
      end
      default: ctl = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Command-side driver for an external 16-bit combinational ALU. Accepts one
// command at a time, drives the ALU for one pass (16-bit ops) or two passes
// (ADD32/SUB32, carry chained through alu_ofl), then holds the response until
// it is accepted.
//   clk, rst            clock, asynchronous active-high reset
//   bus (slave)         command / response handshake
//   alu_a, alu_b        ALU operands (zero outside EXEC states)
//   alu_op, alu_cin, alu_inva, alu_invb, alu_sign   ALU controls
//   alu_out, alu_ofl    ALU result and overflow/carry (same cycle)
// -----------------------------------------------------------------------------
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  alu_seq_if.slave    bus,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_cin,
  output logic        alu_inva,
  output logic        alu_invb,
  output logic        alu_sign,
  input  logic [15:0] alu_out,
  input  logic        alu_ofl
);

  state_e      state_q, state_d;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic        carry_q;
  logic [31:0] data_q;
  logic        ofl_q, zero_q;
  logic        accept;
  dec_t        ctl;
  logic        in_exec;
  logic        alu_eq, alu_lt;
  logic [15:0] res16;

  alu_seq_dec u_dec (
    .op   (op_q),
    .pass (state_q == ST_EXEC2),
    .ctl  (ctl)
  );

  assign accept        = bus.cmd_valid & bus.cmd_ready;
  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_ofl   = ofl_q;
  assign bus.rsp_zero  = zero_q;

  // Compare post-processing on the A - B difference.
  assign alu_eq = (alu_out == 16'h0000);
  assign alu_lt = alu_out[15] ^ alu_ofl;

  always_comb begin
    res16 = alu_out;
    unique case (op_q)
      OP_SEQ:  res16 = {15'd0, alu_eq};
      OP_SLT:  res16 = {15'd0, alu_lt};
      OP_SLE:  res16 = {15'd0, alu_lt | alu_eq};
      OP_SCO:  res16 = {15'd0, alu_ofl};
      default: res16 = alu_out;
    endcase
  end

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_EXEC1;
      ST_EXEC1: state_d = ctl.two_pass ? ST_EXEC2 : ST_RESP;
      ST_EXEC2: state_d = ST_RESP;
      ST_RESP:  if (bus.rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ALU pins: quiet outside EXEC, otherwise from the registered command.
  assign in_exec = (state_q == ST_EXEC1) || (state_q == ST_EXEC2);

  always_comb begin
    alu_a    = 16'h0000;
    alu_b    = 16'h0000;
    alu_op   = 3'd0;
    alu_cin  = 1'b0;
    alu_inva = 1'b0;
    alu_invb = 1'b0;
    alu_sign = 1'b0;
    if (in_exec) begin
      alu_a    = (state_q == ST_EXEC2) ? a_q[31:16] : a_q[15:0];
      alu_b    = (state_q == ST_EXEC2) ? b_q[31:16] : b_q[15:0];
      alu_op   = ctl.alu_op;
      alu_inva = ctl.inva;
      alu_invb = ctl.invb;
      alu_sign = ctl.sign;
      unique case (ctl.cin_sel)
        CIN_ONE:   alu_cin = 1'b1;
        CIN_CARRY: alu_cin = carry_q;
        default:   alu_cin = 1'b0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register. All registers here,
  // operands included, are reset so a dropped command leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      carry_q <= 1'b0;
      data_q  <= 32'd0;
      ofl_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= bus.cmd_op;
        a_q  <= bus.cmd_a;
        b_q  <= bus.cmd_b;
      end
      if (state_q == ST_EXEC1) begin
        if (ctl.two_pass) begin
          carry_q <= alu_ofl;
          data_q  <= {16'h0000, alu_out};
        end else begin
          data_q <= {16'h0000, res16};
          ofl_q  <= is_arith(op_q) & alu_ofl;
          zero_q <= (res16 == 16'h0000);
        end
      end
      if (state_q == ST_EXEC2) begin
        data_q[31:16] <= alu_out;
        ofl_q         <= alu_ofl;
        zero_q        <= ({alu_out, data_q[15:0]} == 32'd0);
      end
    end
  end

endmodule
